// File: rtl/local_xy_inject.sv
// Buffered local-injection port: queues core packets in a small FIFO and routes
// the head dimension-order (X then Y), decrementing the used hop offset on egress.
module local_xy_inject #(
    parameter int PKT_W = 16,
    parameter int DX_W  = 4,
    parameter int DY_W  = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PKT_W-1:0] in_packet,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [PKT_W-1:0] east_packet,
    output logic             east_valid,
    input  logic             east_ready,
    output logic [PKT_W-1:0] west_packet,
    output logic             west_valid,
    input  logic             west_ready,
    output logic [PKT_W-1:0] north_packet,
    output logic             north_valid,
    input  logic             north_ready,
    output logic [PKT_W-1:0] south_packet,
    output logic             south_valid,
    input  logic             south_ready,
    output logic [PKT_W-1:0] local_packet,
    output logic             local_valid,
    input  logic             local_ready,
    output logic [CNT_W-1:0] stall_count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int OCC_W  = $clog2(DEPTH + 1);
    localparam int DX_MSB = PKT_W - 1;
    localparam int DY_MSB = PKT_W - DX_W - 1;
    localparam logic [DX_W-1:0]  DX_ONE = DX_W'(1);
    localparam logic [DY_W-1:0]  DY_ONE = DY_W'(1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    typedef enum logic [2:0] {
        PORT_EAST,
        PORT_WEST,
        PORT_NORTH,
        PORT_SOUTH,
        PORT_LOCAL
    } port_t;

    logic [PKT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] count;

    logic             nonempty;
    logic             push;
    logic             pop;
    logic [PKT_W-1:0] head;
    logic [DX_W-1:0]  dx;
    logic [DY_W-1:0]  dy;
    logic             dx_pos;
    logic             dx_neg;
    logic             dy_pos;
    logic             dy_neg;
    port_t            dest;
    logic [PKT_W-1:0] out_packet;
    logic             sel_ready;

    assign nonempty = (count != '0);
    // Full blocks the input even when a pop is pending, so in_ready never depends on any ready input.
    assign in_ready = (count != OCC_FULL) && !rst;
    assign push     = in_valid && in_ready;
    assign pop      = nonempty && sel_ready;

    assign head   = mem[rd_ptr];
    assign dx     = head[DX_MSB -: DX_W];
    assign dy     = head[DY_MSB -: DY_W];
    assign dx_neg = dx[DX_W-1];
    assign dx_pos = !dx[DX_W-1] && (dx != '0);
    assign dy_neg = dy[DY_W-1];
    assign dy_pos = !dy[DY_W-1] && (dy != '0);

    always_comb begin
        dest       = PORT_LOCAL;
        out_packet = head;
        if (dx_pos) begin
            dest = PORT_EAST;
            out_packet[DX_MSB -: DX_W] = dx - DX_ONE;
        end else if (dx_neg) begin
            dest = PORT_WEST;
            out_packet[DX_MSB -: DX_W] = dx + DX_ONE;
        end else if (dy_pos) begin
            dest = PORT_NORTH;
            out_packet[DY_MSB -: DY_W] = dy - DY_ONE;
        end else if (dy_neg) begin
            dest = PORT_SOUTH;
            out_packet[DY_MSB -: DY_W] = dy + DY_ONE;
        end
    end

    always_comb begin
        sel_ready = local_ready;
        case (dest)
            PORT_EAST:  sel_ready = east_ready;
            PORT_WEST:  sel_ready = west_ready;
            PORT_NORTH: sel_ready = north_ready;
            PORT_SOUTH: sel_ready = south_ready;
            default:    sel_ready = local_ready;
        endcase
    end

    assign east_valid  = nonempty && (dest == PORT_EAST);
    assign west_valid  = nonempty && (dest == PORT_WEST);
    assign north_valid = nonempty && (dest == PORT_NORTH);
    assign south_valid = nonempty && (dest == PORT_SOUTH);
    assign local_valid = nonempty && (dest == PORT_LOCAL);

    assign east_packet  = out_packet;
    assign west_packet  = out_packet;
    assign north_packet = out_packet;
    assign south_packet = out_packet;
    assign local_packet = out_packet;

    // Storage is left unreset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_packet;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (nonempty && !sel_ready && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: doc/local_xy_inject.md
# local_xy_inject

Parametrised, buffered local-injection port for the mesh router: accepts packets from the local core over a valid/ready handshake, queues them in a DEPTH-entry FIFO, and routes the FIFO head dimension-order (X first, then Y) to one of five output ports (east, west, north, south, local). The hop-offset header field of the chosen dimension is updated on egress. The block also keeps a saturating stall counter for performance monitoring. It sits between the local core's network interface and the router crossbar, replacing the combinational X-only local-input splitter.

## Interface
- PKT_W, 16: packet width in bits.
- DX_W, 4: width of signed X offset, packet bits [PKT_W-1 -: DX_W].
- DY_W, 4: width of signed Y offset, packet bits [PKT_W-DX_W-1 -: DY_W].
- DEPTH, 4: FIFO entries; power of two, >= 2.
- CNT_W, 16: stall counter width.

- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_packet  in  PKT_W  packet from local core.
- in_valid  in  1  in_packet is valid.
- in_ready  out  1  FIFO can accept; transfer when in_valid && in_ready.
- {east,west,north,south,local}_packet  out  PKT_W  routed packet, header updated.
- {east,west,north,south,local}_valid  out  1  packet offered on that port.
- {east,west,north,south,local}_ready  in  1  downstream accepts; transfer when valid && ready.
- stall_count  out  CNT_W  cycles the head packet was blocked, saturating.

## Operation
- FIFO: write pointer, read pointer, and occupancy count, all registered. Pointers wrap modulo DEPTH.
- in_ready = (count != DEPTH) && !rst. Push happens on in_valid && in_ready.
- Head routing, with dx and dy taken from the head entry as signed values:
  - dx > 0: east. Egress dx = dx - 1.
  - dx < 0: west. Egress dx = dx + 1.
  - dx == 0, dy > 0: north. Egress dy = dy - 1.
  - dx == 0, dy < 0: south. Egress dy = dy + 1.
  - dx == 0, dy == 0: local. Packet is unchanged.
- Only the modified field changes; all other bits pass through.
- Offsets always move toward zero, so there is no overflow. The most negative value (-8 at DX_W = 4) is legal.
- Exactly one *_valid is high when count > 0; all are 0 when the FIFO is empty.
- All five *_packet outputs carry the same updated head value. Only the selected valid qualifies it.
- Pop happens on selected_valid && selected_ready. Ready inputs of non-selected ports are ignored.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- When full, in_ready = 0 in that cycle even if a pop occurs. There is no full-bypass.
- stall_count:
  - +1 each cycle the FIFO is non-empty and the selected port's ready is 0.
  - Saturates at 2^CNT_W - 1.
  - Cleared only by rst.

## Timing
- rst sampled high at an edge: count, pointers and stall_count go to 0.
  - All *_valid are 0 from that edge onward.
  - in_ready is 0 while rst is high and 1 in the first cycle after rst deasserts.
- rst mid-operation discards all queued packets. There is no partial transfer.
- FIFO memory contents need no reset.
- Latency: a packet pushed at edge N is presented on its output port in the cycle after edge N, at the earliest.
- Output valid and packet are combinational from registered FIFO state. There is no combinational path from any *_ready to in_ready.
- Throughput: one packet per cycle sustained when the selected port is ready every cycle.
- Ordering: strict FIFO across all ports. A blocked head blocks younger packets bound for other ports (head-of-line blocking is accepted).

## Test plan
- Routing, all readys = 1, sent one at a time:
  - 16'h3000 -> east_valid=1, east_packet=16'h2000.
  - 16'hE000 -> west_packet=16'hF000.
  - 16'h0200 -> north_packet=16'h0100.
  - 16'h0E00 -> south_packet=16'h0F00.
  - 16'h0005 -> local_packet=16'h0005.
  - Each appears in the cycle after acceptance; other valids stay 0.
- Boundary offsets: 16'h8000 -> west 16'h9000; 16'h7000 -> east 16'h6000; 16'h0800 (dy=-8) -> south 16'h0900.
- Full/backpressure: DEPTH=4, east_ready=0, push 5 packets of 16'h1000.
  - in_ready drops after the 4th push; the 5th is held.
  - stall_count increments every cycle.
  - After east_ready=1, four 16'h0000 packets emerge in order on east, one per cycle, then the 5th.
- Streaming with simultaneous push/pop: continuous in_valid, all readys = 1, 20 packets cycling through all five destinations.
  - Count never exceeds 1; order is preserved.
  - Pointers wrap correctly past DEPTH.
- Head-of-line blocking: queue 16'h1000 then 16'h0000, east_ready=0, local_ready=1.
  - local_valid stays 0 until east_ready=1.
- Reset mid-operation: 3 packets queued, assert rst for 1 cycle.
  - All valids 0, stall_count = 0, in_ready = 0 during rst and 1 after.
  - No old packet reappears.
